// File: rtl/yu_yg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : yu_yg_pkg
//  Description : Shared constants for the yu_yg decoder-based function block:
//                decoder width, decoder output indices used by the top-level
//                gate network, and the decoder idle/reset pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
package yu_yg_pkg;

  // Width of one 2-to-4 decoder output vector
  localparam int DEC_W = 4;

  // Decoder AB output indices whose NAND forms (A xor B)
  localparam int IDX_AB01 = 1;
  localparam int IDX_AB10 = 2;

  // Decoder CD output index that is low only for CD=01, giving (C | ~D)
  localparam int IDX_CD01 = 1;

  // Idle pattern of an active-low decoder: every output deasserted
  localparam logic [DEC_W-1:0] DEC_RST = '1;

endpackage : yu_yg_pkg
`default_nettype wire

// File: rtl/yu_yg_dec.sv
`default_nettype none
// ============================================================================
//  Module      : dec2x4_n
//  Description : 2-to-4 decoder with active-high enable and active-low
//                outputs. The selected output is driven low when enabled;
//                all outputs are high when disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module dec2x4_n
  import yu_yg_pkg::*;
(
  input  logic             en_i,
  input  logic [1:0]       sel_i,
  output logic [DEC_W-1:0] dec_n_o
);

  // Pull the selected line low only while enabled
  always_comb begin
    dec_n_o = DEC_RST;
    if (en_i) begin
      dec_n_o[sel_i] = 1'b0;
    end
  end

endmodule : dec2x4_n
`default_nettype wire

// File: rtl/yu_yg.sv
`default_nettype none
// ============================================================================
//  Module      : yu_yg
//  Description : F = en & (A xor B) & (C | ~D), built from two active-low
//                2-to-4 decoders plus a small gate network. REG_OUT selects
//                a registered (1-cycle) or combinational output.
//                Optional macro YU_YG_DEC_OBS_EN adds registered observation
//                ports dec_ab_n / dec_cd_n carrying the raw decoder outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module yu_yg
  import yu_yg_pkg::*;
#(
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
`ifdef YU_YG_DEC_OBS_EN
  output logic [DEC_W-1:0] dec_ab_n,
  output logic [DEC_W-1:0] dec_cd_n,
`endif
  output logic             f
);

  logic [DEC_W-1:0] ab_n;
  logic [DEC_W-1:0] cd_n;
  logic             xor_t;
  logic             cd_t;
  logic             f_d;

  dec2x4_n u_dec_ab (
    .en_i    (en),
    .sel_i   ({a, b}),
    .dec_n_o (ab_n)
  );

  dec2x4_n u_dec_cd (
    .en_i    (en),
    .sel_i   ({c, d}),
    .dec_n_o (cd_n)
  );

  // AB=01 or AB=10 pulls one of these two lines low; disabled leaves both high
  assign xor_t = ~(ab_n[IDX_AB01] & ab_n[IDX_AB10]);
  assign cd_t  = cd_n[IDX_CD01];
  assign f_d   = xor_t & cd_t;

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic f_q;

      // Output register; reset wins over any new data
      always_ff @(posedge clk) begin
        if (rst) begin
          f_q <= 1'b0;
        end else begin
          f_q <= f_d;
        end
      end

      assign f = f_q;
    end else begin : g_comb_out
      assign f = f_d;
    end
  endgenerate

`ifdef YU_YG_DEC_OBS_EN
  logic [DEC_W-1:0] dec_ab_q;
  logic [DEC_W-1:0] dec_cd_q;

  // Debug capture of the raw decoder vectors
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_ab_q <= DEC_RST;
      dec_cd_q <= DEC_RST;
    end else begin
      dec_ab_q <= ab_n;
      dec_cd_q <= cd_n;
    end
  end

  assign dec_ab_n = dec_ab_q;
  assign dec_cd_n = dec_cd_q;
`endif

endmodule : yu_yg
`default_nettype wire

// File: tb/tb_yu_yg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_yu_yg
//  Description : Self-checking bench for yu_yg. Drives a registered-output
//                instance and a combinational-output instance from the same
//                stimulus; a truth-table model predicts f every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_yu_yg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] abcd;
  logic       f_reg;
  logic       f_comb;
`ifdef YU_YG_DEC_OBS_EN
  logic [3:0] dec_ab_n;
  logic [3:0] dec_cd_n;
  logic [3:0] dec_ab_c;
  logic [3:0] dec_cd_c;
  logic [3:0] exp_ab_q;
  logic [3:0] exp_cd_q;
`endif

  int total;
  int bad;
  bit chk_en;

  // Truth table of F over ABCD (bit index = ABCD): 4,6,7,8,10,11 are ones
  logic [15:0] tbl;
  logic        exp_q;

  yu_yg #(.REG_OUT(1)) u_dut_reg (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .a        (abcd[3]),
    .b        (abcd[2]),
    .c        (abcd[1]),
    .d        (abcd[0]),
`ifdef YU_YG_DEC_OBS_EN
    .dec_ab_n (dec_ab_n),
    .dec_cd_n (dec_cd_n),
`endif
    .f        (f_reg)
  );

  yu_yg #(.REG_OUT(0)) u_dut_comb (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .a        (abcd[3]),
    .b        (abcd[2]),
    .c        (abcd[1]),
    .d        (abcd[0]),
`ifdef YU_YG_DEC_OBS_EN
    .dec_ab_n (dec_ab_c),
    .dec_cd_n (dec_cd_c),
`endif
    .f        (f_comb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_f(input logic e, input logic [3:0] v);
    return e & tbl[v];
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the registered paths, advanced on each rising edge
  always @(posedge clk) begin
    exp_q = rst ? 1'b0 : model_f(en, abcd);
`ifdef YU_YG_DEC_OBS_EN
    exp_ab_q = (rst || !en) ? 4'hF : ~(4'b0001 << abcd[3:2]);
    exp_cd_q = (rst || !en) ? 4'hF : ~(4'b0001 << abcd[1:0]);
`endif
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("f_reg_model", {3'b0, f_reg}, {3'b0, exp_q});
      check("f_comb_model", {3'b0, f_comb}, {3'b0, model_f(en, abcd)});
`ifdef YU_YG_DEC_OBS_EN
      check("dec_ab_model", dec_ab_n, exp_ab_q);
      check("dec_cd_model", dec_cd_n, exp_cd_q);
`endif
    end
  end

  // Apply inputs just after a rising edge
  task automatic drive(input logic r, input logic e, input logic [3:0] v);
    @(posedge clk);
    #1;
    rst  = r;
    en   = e;
    abcd = v;
  endtask

  // Check the registered f produced by the inputs currently applied
  task automatic expect_reg(input string name, input logic exp);
    @(posedge clk);
    @(negedge clk);
    check(name, {3'b0, f_reg}, {3'b0, exp});
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    tbl    = 16'h0DD0;
    rst    = 1'b1;
    en     = 1'b1;
    abcd   = 4'b1000;

    // Scenario 1: two reset cycles with a one-producing input
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_cyc1", {3'b0, f_reg}, 4'd0);
    expect_reg("rst_cyc2", 1'b0);
    drive(1'b0, 1'b1, 4'b1000);
    @(negedge clk);
    check("rst_held_until_edge", {3'b0, f_reg}, 4'd0);
    expect_reg("first_after_rst", 1'b1);

    // Scenario 2: full sweep, model compares each cycle
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 4'(i));
    end
    expect_reg("sweep_1111", 1'b0);

    // Scenario 3
    drive(1'b0, 1'b1, 4'b1001);
    expect_reg("abcd_1001", 1'b0);
    drive(1'b0, 1'b1, 4'b1011);
    expect_reg("abcd_1011", 1'b1);

    // Mid-stream reset clears f on the next edge
    drive(1'b1, 1'b1, 4'b1011);
    expect_reg("mid_rst_clear", 1'b0);
    drive(1'b0, 1'b1, 4'b0111);
    expect_reg("abcd_0111", 1'b1);

    // Scenario 4: disabled
    drive(1'b0, 1'b0, 4'b0110);
    expect_reg("en0_0110", 1'b0);
`ifdef YU_YG_DEC_OBS_EN
    check("en0_dec_ab", dec_ab_n, 4'b1111);
    check("en0_dec_cd", dec_cd_n, 4'b1111);
`endif

    // Scenario 5: enabled 0110
    drive(1'b0, 1'b1, 4'b0110);
    expect_reg("en1_0110", 1'b1);
`ifdef YU_YG_DEC_OBS_EN
    check("dec_ab_0110", dec_ab_n, 4'b1101);
    check("dec_cd_0110", dec_cd_n, 4'b1011);
`endif

    // Scenario 6: combinational instance, same-cycle response, immune to rst
    drive(1'b0, 1'b1, 4'b0100);
    #1;
    check("comb_0100", {3'b0, f_comb}, 4'd1);
    rst = 1'b1;
    #1;
    check("comb_0100_rst", {3'b0, f_comb}, 4'd1);
    @(negedge clk);
    check("comb_0100_rst_edge", {3'b0, f_comb}, 4'd1);
    expect_reg("reg_0100_rst", 1'b0);
    drive(1'b0, 1'b1, 4'b0101);
    #1;
    check("comb_0101", {3'b0, f_comb}, 4'd0);
    expect_reg("reg_0101", 1'b0);

    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_yu_yg
`default_nettype wire

// File: doc/yu_yg.md
YU_YG -- requirements
Module: yu_yg

Interface
REQ-001 The block SHALL expose parameter REG_OUT, default 1, meaning f is registered (1) or combinational (0).
REQ-002 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port en, input, 1 bit: positive-polarity enable for both decoders.
REQ-005 The block SHALL have port a, input, 1 bit: function input A (MSB of ABCD).
REQ-006 The block SHALL have port b, input, 1 bit: function input B.
REQ-007 The block SHALL have port c, input, 1 bit: function input C.
REQ-008 The block SHALL have port d, input, 1 bit: function input D (LSB).
REQ-009 The block SHALL have port f, output, 1 bit: F = en & (A xor B) & (C | ~D).

Function
REQ-010 The block SHALL build F structurally from two 2-to-4 decoders with active-low outputs and active-high enable: decoder AB (select a,b) and decoder CD (select c,d).
REQ-011 Each decoder SHALL drive output index {s1,s0} low when enabled and all other outputs high; when disabled, all outputs SHALL be high.
REQ-012 The (A xor B) term SHALL be the NAND of decoder AB outputs 1 and 2.
REQ-013 The (C | ~D) term SHALL be decoder CD output 1, i.e. low only for CD=01.
REQ-014 The F term SHALL be the AND of the two terms; with en=0, F SHALL be 0.
REQ-015 With REG_OUT=1, f SHALL equal the F term sampled at the previous rising clk edge, giving 1-cycle latency.
REQ-016 With REG_OUT=0, f SHALL be purely combinational, with 0-cycle latency; clk and rst then affect only the debug registers.
REQ-017 F SHALL be 1 exactly for ABCD in {1000, 1010, 1011, 0100, 0110, 0111} with en=1, and 0 for every other input combination.
REQ-018 No X SHALL propagate to f when all inputs are known; no latches SHALL be inferred.

Reset
REQ-019 When rst=1 at a rising edge, the registered f SHALL become 0, regardless of en and the inputs.
REQ-020 rst SHALL take precedence over new data in the same cycle; the first valid output SHALL appear at the edge after rst is released.
REQ-021 When rst is asserted mid-stream, the next edge SHALL clear f with no residual value.

Configuration
REQ-022 When macro YU_YG_DEC_OBS_EN is defined, the block SHALL add output dec_ab_n [3:0] and output dec_cd_n [3:0], carrying the registered raw decoder outputs with 1-cycle latency and reset value 4'b1111.
REQ-023 Without YU_YG_DEC_OBS_EN, those ports and their registers SHALL NOT exist, and the f behaviour SHALL be identical.

Structure
REQ-024 A shared package yu_yg_pkg SHALL hold the decoder width constant DEC_W=4, the index constants IDX_AB01=1, IDX_AB10=2 and IDX_CD01=1, and the reset constant DEC_RST='1.
REQ-025 One sub-module, dec2x4_n (2-to-4, active-low outputs, active-high enable), SHALL be instantiated twice.
REQ-026 The top level SHALL contain only gate-level combination of the decoder outputs plus the output and debug registers.

Verification
REQ-027 Scenario 1: rst=1 for 2 cycles with ABCD=1000 and en=1 -> f=0 throughout reset, then f=1 one cycle after rst falls.
REQ-028 Scenario 2: en=1, sweep ABCD 0000..1111 at one value per cycle -> f matches the REQ-017 table, delayed by 1 cycle.
REQ-029 Scenario 3: en=1, ABCD=1001 -> f=0; then ABCD=1011 -> f=1.
REQ-030 Scenario 4: en=0, ABCD=0110 -> f=0; with YU_YG_DEC_OBS_EN defined, dec_ab_n=1111 and dec_cd_n=1111.
REQ-031 Scenario 5: YU_YG_DEC_OBS_EN defined, en=1, ABCD=0110 -> dec_ab_n=1101 and dec_cd_n=1011 one cycle later.
REQ-032 Scenario 6: REG_OUT=0, ABCD=0100 and en=1 -> f=1 in the same cycle; assert rst -> f stays 1.
